button_event_detector: RTL and testbench

//   Consumes the debounced, stable button levels produced by the input debouncer.

---
 rtl/button_event_detector.sv | 130 +++++++++++++
 tb/tb_button_event_detector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/button_event_detector.sv
// button_event_detector
//   Turns debounced button levels into single-cycle event pulses:
//   press, release, long-press and auto-repeat, plus a long-hold level.
//   Each of the N_BTN channels runs its own small FSM and counter.
//   Optional feature macro: BTN_EVT_REPEAT_EN
//     defined   -> LONG state runs the repeat counter and drives repeat_o
//     undefined -> no repeat logic; repeat_o is tied low
module button_event_detector #(
  parameter int N_BTN      = 2,
  parameter int LONG_CYC   = 1000,
  parameter int REPEAT_CYC = 250,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] long_o,
  output logic [N_BTN-1:0] repeat_o,
  output logic [N_BTN-1:0] held_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_LONG  = 2'd2;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef BTN_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
`else
  localparam int unused_repeat_cyc = REPEAT_CYC;
`endif

  logic [N_BTN-1:0] btn_q;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;

  // Previous-level register for edge detection; cleared so a held button re-presses after reset
  always_ff @(posedge clk) begin
    if (rst) btn_q <= '0;
    else     btn_q <= btn_i;
  end

  assign rise = btn_i & ~btn_q;
  assign fall = ~btn_i & btn_q;

  for (genvar c = 0; c < N_BTN; c++) begin : g_ch
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             press_r;
    logic             release_r;
    logic             long_r;
`ifdef BTN_EVT_REPEAT_EN
    logic             repeat_r;
`endif

    // Per-channel event FSM; release always takes priority over a threshold hit
    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= S_IDLE;
        cnt       <= '0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
        repeat_r  <= 1'b0;
`endif
      end else begin
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
        repeat_r  <= 1'b0;
`endif
        case (state)
          S_IDLE: begin
            if (rise[c]) begin
              press_r <= 1'b1;
              cnt     <= '0;
              state   <= S_PRESS;
            end
          end
          S_PRESS: begin
            if (fall[c]) begin
              release_r <= 1'b1;
              cnt       <= '0;
              state     <= S_IDLE;
            end else if (cnt == LONG_LAST) begin
              long_r <= 1'b1;
              cnt    <= '0;
              state  <= S_LONG;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_LONG: begin
            if (fall[c]) begin
              release_r <= 1'b1;
              cnt       <= '0;
              state     <= S_IDLE;
`ifdef BTN_EVT_REPEAT_EN
            end else if (cnt == REPEAT_LAST) begin
              repeat_r <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
`endif
            end
          end
          default: begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        endcase
      end
    end

    assign press_o[c]   = press_r;
    assign release_o[c] = release_r;
    assign long_o[c]    = long_r;
    assign held_o[c]    = (state == S_LONG);
`ifdef BTN_EVT_REPEAT_EN
    assign repeat_o[c]  = repeat_r;
`else
    assign repeat_o[c]  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_event_detector.sv
// Bench for button_event_detector (LONG_CYC=8, REPEAT_CYC=4, N_BTN=2).
// Follows BTN_EVT_REPEAT_EN to decide whether repeat pulses are expected.
module tb_button_event_detector;

  localparam int N_BTN      = 2;
  localparam int LONG_CYC   = 8;
  localparam int REPEAT_CYC = 4;
  localparam int CNT_W      = 16;
`ifdef BTN_EVT_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_BTN-1:0] btn = '0;
  logic [N_BTN-1:0] press_o, release_o, long_o, repeat_o, held_o;

  button_event_detector #(
    .N_BTN(N_BTN), .LONG_CYC(LONG_CYC), .REPEAT_CYC(REPEAT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .btn_i(btn),
    .press_o(press_o), .release_o(release_o), .long_o(long_o),
    .repeat_o(repeat_o), .held_o(held_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per channel, previous sampled level and number of
  // cycles the current press has lasted.
  bit               m_prev [N_BTN];
  int               m_n    [N_BTN];
  logic [N_BTN-1:0] e_press, e_rel, e_long, e_rep, e_held;

  task automatic chk(input string nm, input logic [N_BTN-1:0] act, input logic [N_BTN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_held = '0;
    for (int c = 0; c < N_BTN; c++) begin
      if (rst) begin
        m_prev[c] = 1'b0;
        m_n[c]    = 0;
      end else begin
        if (btn[c] && !m_prev[c]) begin
          e_press[c] = 1'b1;
          m_n[c]     = 0;
        end else if (btn[c]) begin
          m_n[c]++;
          if (m_n[c] == LONG_CYC) e_long[c] = 1'b1;
          if (REP_ON && m_n[c] > LONG_CYC && ((m_n[c] - LONG_CYC) % REPEAT_CYC) == 0)
            e_rep[c] = 1'b1;
        end else if (m_prev[c]) begin
          e_rel[c] = 1'b1;
        end
        e_held[c] = btn[c] && (m_n[c] >= LONG_CYC);
        m_prev[c] = btn[c];
      end
    end
  endtask

  // One clock: model follows the inputs seen at the edge, outputs checked 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_press",   press_o,   e_press);
    chk("model_release", release_o, e_rel);
    chk("model_long",    long_o,    e_long);
    chk("model_repeat",  repeat_o,  e_rep);
    chk("model_held",    held_o,    e_held);
  endtask

  typedef struct {
    logic             rst;
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;
    logic [N_BTN-1:0] lng;
    logic [N_BTN-1:0] held;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // Reset with a button held, then a 5-cycle short press
    tbl[0]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[3]  = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    tbl[6]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[7]  = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[8]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[9]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[11] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[12] = '{1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    tbl[13] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    rst = 1'b1; btn = '0;
    tick(); tick();

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      btn = tbl[i].btn;
      tick();
      chk($sformatf("tbl%0d_press", i),   press_o,   tbl[i].press);
      chk($sformatf("tbl%0d_release", i), release_o, tbl[i].rel);
      chk($sformatf("tbl%0d_long", i),    long_o,    tbl[i].lng);
      chk($sformatf("tbl%0d_repeat", i),  repeat_o,  2'b00);
      chk($sformatf("tbl%0d_held", i),    held_o,    tbl[i].held);
    end

    // Long press held 20 cycles: long at +8, repeats at +12 and +16
    btn = 2'b01; tick();
    chk("t3_press", press_o, 2'b01);
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("t3_long", long_o, (i == 8) ? 2'b01 : 2'b00);
      chk("t3_repeat", repeat_o, (REP_ON && (i == 12 || i == 16)) ? 2'b01 : 2'b00);
      chk("t3_held", held_o, (i >= 8) ? 2'b01 : 2'b00);
    end
    btn = 2'b00; tick();
    chk("t3_release", release_o, 2'b01);
    chk("t3_held_off", held_o, 2'b00);
    chk("t3_no_rep_at_rel", repeat_o, 2'b00);
    tick();

    // Release on the cycle the long threshold would be reached
    btn = 2'b01; tick();
    for (int i = 1; i < 8; i++) tick();
    btn = 2'b00; tick();
    chk("t4_release", release_o, 2'b01);
    chk("t4_no_long", long_o, 2'b00);
    chk("t4_no_held", held_o, 2'b00);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_idle_long", long_o, 2'b00);
    end
    btn = 2'b01; tick();
    chk("t4_repress", press_o, 2'b01);
    btn = 2'b00; tick();
    chk("t4_rerelease", release_o, 2'b01);
    tick();

    // Independent channels
    btn = 2'b11; tick();
    chk("t5_press", press_o, 2'b11);
    for (int i = 1; i < 4; i++) tick();
    btn = 2'b01; tick();
    chk("t5_release1", release_o, 2'b10);
    for (int i = 5; i <= 8; i++) begin
      tick();
      chk("t5_long0", long_o, (i == 8) ? 2'b01 : 2'b00);
    end
    chk("t5_held0", held_o, 2'b01);
    btn = 2'b00; tick();
    chk("t5_release0", release_o, 2'b01);
    tick();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < N_BTN; c++)
        if ($urandom_range(0, 11) == 0) btn[c] = ~btn[c];
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
